// File: rtl/gat_bram_port_adapter.sv
// Host-to-core BRAM load adapter: qualifies host writes per channel, tracks load progress
// against a programmed word count, and forwards pipelined readbacks from the core result memory.
module gat_bram_port_adapter #(
    parameter int TOP_WIDTH  = 32,
    parameter int NUM_CH     = 3,
    parameter int ADDR_W     = 18,
    parameter int CNT_W      = 19,
    parameter int RD_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_start,
    input  logic [NUM_CH*CNT_W-1:0]      expected_words,
    input  logic [NUM_CH*TOP_WIDTH-1:0]  bram_din,
    input  logic [NUM_CH-1:0]            bram_ena,
    input  logic [NUM_CH-1:0]            bram_wea,
    input  logic [NUM_CH*(ADDR_W+2)-1:0] bram_addra,
    output logic [NUM_CH*TOP_WIDTH-1:0]  core_din,
    output logic [NUM_CH-1:0]            core_we,
    output logic [NUM_CH*ADDR_W-1:0]     core_addr,
    output logic [NUM_CH-1:0]            load_done,
    output logic [NUM_CH-1:0]            load_err,
    output logic                         all_loaded,
    input  logic                         rd_req,
    input  logic [ADDR_W+1:0]            rd_addrb,
    output logic [ADDR_W-1:0]            core_rd_addr,
    input  logic [TOP_WIDTH-1:0]         core_rd_dout,
    output logic [TOP_WIDTH-1:0]         rd_dout,
    output logic                         rd_valid
);
    localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_DONE    = 2'd2
    } ld_state_t;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        ld_state_t            state_r;
        logic [CNT_W-1:0]     count_r;
        logic [CNT_W-1:0]     count_inc_s;
        logic [CNT_W-1:0]     exp_words_s;
        logic [ADDR_W+1:0]    byte_addr_s;
        logic [ADDR_W-1:0]    word_addr_s;
        logic [CMP_W-1:0]     word_cmp_s;
        logic [CMP_W-1:0]     exp_cmp_s;
        logic                 strobe_s;
        logic                 accept_s;
        logic                 reject_s;
        logic                 done_r;
        logic                 err_r;
        logic                 we_r;
        logic [ADDR_W-1:0]    addr_r;
        logic [TOP_WIDTH-1:0] din_r;

        // Write qualification; a write coinciding with load_start never reaches the checks.
        always_comb begin
            exp_words_s = expected_words[ch*CNT_W +: CNT_W];
            byte_addr_s = bram_addra[ch*(ADDR_W+2) +: (ADDR_W+2)];
            word_addr_s = byte_addr_s[ADDR_W+1:2];
            word_cmp_s  = CMP_W'(word_addr_s);
            exp_cmp_s   = CMP_W'(exp_words_s);
            count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            strobe_s    = bram_ena[ch] & bram_wea[ch] & ~load_start;
            if (strobe_s && (byte_addr_s[1:0] == 2'b00) && (word_cmp_s < exp_cmp_s)
                && (state_r != ST_DONE)) begin
                accept_s = 1'b1;
            end else begin
                accept_s = 1'b0;
            end
            reject_s = strobe_s & ~accept_s;
        end

        // Load progress FSM with sticky error and done flags.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= ST_IDLE;
                count_r <= '0;
                done_r  <= 1'b0;
                err_r   <= 1'b0;
            end else if (load_start) begin
                count_r <= '0;
                err_r   <= 1'b0;
                if (exp_words_s == '0) begin
                    state_r <= ST_DONE;
                    done_r  <= 1'b1;
                end else begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
            end else begin
                if (reject_s) begin
                    err_r <= 1'b1;
                end
                case (state_r)
                    ST_IDLE, ST_LOADING: begin
                        if (accept_s) begin
                            count_r <= count_inc_s;
                            state_r <= (count_inc_s == exp_words_s) ? ST_DONE : ST_LOADING;
                        end
                    end
                    // done follows DONE by one cycle so it trails the final core_we pulse
                    ST_DONE: done_r <= 1'b1;
                    default: state_r <= ST_IDLE;
                endcase
            end
        end

        // Registered core-side write port.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                we_r   <= 1'b0;
                addr_r <= '0;
                din_r  <= '0;
            end else begin
                we_r <= accept_s;
                if (accept_s) begin
                    addr_r <= word_addr_s;
                    din_r  <= bram_din[ch*TOP_WIDTH +: TOP_WIDTH];
                end
            end
        end

        assign core_we[ch]                           = we_r;
        assign core_addr[ch*ADDR_W +: ADDR_W]        = addr_r;
        assign core_din[ch*TOP_WIDTH +: TOP_WIDTH]   = din_r;
        assign load_done[ch]                         = done_r;
        assign load_err[ch]                          = err_r;
    end

    assign all_loaded = &load_done;

    logic [RD_LATENCY:0]  rd_pipe_r;
    logic [ADDR_W-1:0]    rd_addr_r;
    logic [TOP_WIDTH-1:0] rd_hold_r;
    logic [1:0]           unused_rd_lsb_s;

    assign unused_rd_lsb_s = rd_addrb[1:0];

    // Readback address register, valid pipeline matching the core memory latency, data hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_r <= '0;
            rd_pipe_r <= '0;
            rd_hold_r <= '0;
        end else begin
            if (rd_req) begin
                rd_addr_r <= rd_addrb[ADDR_W+1:2];
            end
            rd_pipe_r <= {rd_pipe_r[RD_LATENCY-1:0], rd_req};
            if (rd_pipe_r[RD_LATENCY]) begin
                rd_hold_r <= core_rd_dout;
            end
        end
    end

    // Memory data is only valid in the rd_valid cycle itself, so it is passed through then and held after.
    assign core_rd_addr = rd_addr_r;
    assign rd_valid     = rd_pipe_r[RD_LATENCY];
    assign rd_dout      = rd_pipe_r[RD_LATENCY] ? core_rd_dout : rd_hold_r;

endmodule

// File: tb/tb_gat_bram_port_adapter.sv
// Self-checking bench for gat_bram_port_adapter: vector table for single writes,
// scoreboard queues for core writes and readbacks, hand sequences for multi-cycle cases.
`timescale 1ns/1ps
module tb_gat_bram_port_adapter;
    localparam int TW = 32;
    localparam int NC = 3;
    localparam int AW = 18;
    localparam int CW = 19;
    localparam int RL = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 load_start;
    logic [NC*CW-1:0]     expected_words;
    logic [NC*TW-1:0]     bram_din;
    logic [NC-1:0]        bram_ena;
    logic [NC-1:0]        bram_wea;
    logic [NC*(AW+2)-1:0] bram_addra;
    logic [NC*TW-1:0]     core_din;
    logic [NC-1:0]        core_we;
    logic [NC*AW-1:0]     core_addr;
    logic [NC-1:0]        load_done;
    logic [NC-1:0]        load_err;
    logic                 all_loaded;
    logic                 rd_req;
    logic [AW+1:0]        rd_addrb;
    logic [AW-1:0]        core_rd_addr;
    logic [TW-1:0]        core_rd_dout;
    logic [TW-1:0]        rd_dout;
    logic                 rd_valid;

    gat_bram_port_adapter #(
        .TOP_WIDTH(TW), .NUM_CH(NC), .ADDR_W(AW), .CNT_W(CW), .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .expected_words(expected_words),
        .bram_din(bram_din), .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
        .core_din(core_din), .core_we(core_we), .core_addr(core_addr),
        .load_done(load_done), .load_err(load_err), .all_loaded(all_loaded),
        .rd_req(rd_req), .rd_addrb(rd_addrb), .core_rd_addr(core_rd_addr),
        .core_rd_dout(core_rd_dout), .rd_dout(rd_dout), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    function automatic logic [TW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {14'd0, a};
    endfunction

    // Core result memory: RL register stages after the address.
    logic [TW-1:0] mem_pipe [RL];
    always @(posedge clk) begin
        mem_pipe[0] <= mem_word(core_rd_addr);
        for (int i = 1; i < RL; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign core_rd_dout = mem_pipe[RL-1];

    typedef struct { int ch; logic [AW-1:0] addr; logic [TW-1:0] data; int due; } wr_exp_t;
    typedef struct { logic [TW-1:0] data; int due; } rd_exp_t;
    typedef struct { int ch; logic [AW+1:0] addr; logic wea; logic acc; logic err; logic done; logic all; } vec_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    vec_t    vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Output monitor: every core_we and rd_valid must match the head of its scoreboard queue.
    always @(negedge clk) begin
        wr_exp_t we;
        rd_exp_t re;
        for (int c = 0; c < NC; c++) begin
            if (core_we[c] === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    $display("FAIL wr_spurious: got core_we on ch%0d addr 0x%0h, expected none (cycle %0d)",
                             c, core_addr[c*AW +: AW], cyc);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_ch", c, we.ch);
                    check("wr_addr", core_addr[c*AW +: AW], we.addr);
                    check("wr_data", core_din[c*TW +: TW], we.data);
                    check("wr_cycle", cyc, we.due);
                end
            end
        end
        if (rd_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++;
                $display("FAIL rd_spurious: got rd_valid data 0x%0h, expected none (cycle %0d)", rd_dout, cyc);
            end else begin
                re = rd_q.pop_front();
                check("rd_data", rd_dout, re.data);
                check("rd_cycle", cyc, re.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bram_ena = '0;
        bram_wea = '0;
        rd_req   = 1'b0;
    endtask

    task automatic drive_wr(input int ch, input logic [AW+1:0] addr, input logic wea,
                            input logic [TW-1:0] din, input logic exp_acc);
        bram_ena = '0;
        bram_wea = '0;
        bram_ena[ch] = 1'b1;
        bram_wea[ch] = wea;
        bram_addra[ch*(AW+2) +: (AW+2)] = addr;
        bram_din[ch*TW +: TW] = din;
        if (exp_acc) wr_q.push_back('{ch, addr[AW+1:2], din, cyc + 1});
    endtask

    task automatic drive_rd(input logic [AW+1:0] addr);
        rd_req   = 1'b1;
        rd_addrb = addr;
        rd_q.push_back('{mem_word(addr[AW+1:2]), cyc + RL + 1});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_we"}, core_we, 0);
        check({tag, "_core_addr"}, core_addr, 0);
        check({tag, "_core_din"}, core_din, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_err"}, load_err, 0);
        check({tag, "_all_loaded"}, all_loaded, 0);
        check({tag, "_core_rd_addr"}, core_rd_addr, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_dout"}, rd_dout, 0);
    endtask

    initial begin
        // ch, byte addr, wea, accepted, err, done, all_loaded (ch0=4, ch1=3, ch2=2 words)
        vecs[0] = '{2, 20'h00007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 20'h00006, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1, 20'h00000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1, 20'h00004, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1, 20'h00004, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{2, 20'h00008, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{2, 20'h00000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{2, 20'h00004, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{2, 20'h00000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{0, 20'h0000C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        load_start = 1'b0;
        expected_words = {19'd2, 19'd3, 19'd4};
        bram_din = '0;
        bram_addra = '0;
        rd_addrb = '0;
        idle();
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("start_done", load_done, 3'b000);
        check("start_err", load_err, 3'b000);

        // Four back-to-back ch0 writes; done two cycles after the last strobe.
        for (int i = 0; i < 4; i++) begin
            drive_wr(0, 20'(i * 4), 1'b1, 32'hA000_0000 + i, 1'b1);
            tick();
        end
        idle();
        check("seqA_done_early", load_done[0], 1'b0);
        tick();
        check("seqA_done", load_done[0], 1'b1);
        check("seqA_err", load_err[0], 1'b0);

        for (int i = 0; i < 10; i++) begin
            drive_wr(vecs[i].ch, vecs[i].addr, vecs[i].wea, 32'h1000_0000 + i, vecs[i].acc);
            tick();
            idle();
            tick();
            check($sformatf("vec%0d_err", i), load_err[vecs[i].ch], vecs[i].err);
            check($sformatf("vec%0d_done", i), load_done[vecs[i].ch], vecs[i].done);
            check($sformatf("vec%0d_all", i), all_loaded, vecs[i].all);
        end

        // load_start with a simultaneous ch0 write; ch1 programmed for zero words.
        expected_words = {19'd2, 19'd0, 19'd4};
        load_start = 1'b1;
        drive_wr(0, 20'h00000, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        load_start = 1'b0;
        idle();
        check("ls_done", load_done, 3'b010);
        check("ls_err", load_err, 3'b000);
        check("ls_all", all_loaded, 1'b0);
        tick();
        check("ls_done_hold", load_done, 3'b010);
        drive_wr(1, 20'h00000, 1'b1, 32'h0000_0001, 1'b0);
        tick();
        idle();
        tick();
        check("zero_ch_err", load_err, 3'b010);

        // Back-to-back readbacks, the last one with nonzero byte-offset bits.
        drive_rd(20'h00000);
        tick();
        drive_rd(20'h00004);
        tick();
        drive_rd(20'h00008);
        tick();
        drive_rd(20'h00013);
        tick();
        idle();
        check("rd_addr_last", core_rd_addr, 18'd4);
        repeat (5) tick();
        check("rd_addr_hold", core_rd_addr, 18'd4);
        check("rd_valid_idle", rd_valid, 1'b0);
        check("rd_dout_hold", rd_dout, mem_word(18'd4));

        // Reset mid-load (3 of 4) with a readback in flight.
        for (int i = 0; i < 3; i++) begin
            drive_wr(0, 20'(i * 4), 1'b1, 32'hB000_0000 + i, 1'b1);
            tick();
        end
        idle();
        tick();
        tick();
        rd_req = 1'b1;
        rd_addrb = 20'h00010;
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_reset_done", load_done[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_wr(0, 20'(i * 4), 1'b1, 32'hC000_0000 + i, 1'b1);
            tick();
        end
        idle();
        tick();
        tick();
        check("fresh3_done", load_done[0], 1'b0);
        drive_wr(0, 20'h0000C, 1'b1, 32'hC000_0003, 1'b1);
        tick();
        idle();
        tick();
        check("fresh4_done", load_done[0], 1'b1);
        check("fresh4_err", load_err[0], 1'b0);

        repeat (4) tick();
        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
